// File: rtl/alu_operand_stage_if.sv
// Decode-side request, write-back port and ALU-side response bundle for the operand stage.
// The master drives decode fields, write-back and out_ready. The slave (the stage) returns in_ready and the registered operands.
interface alu_operand_stage_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int IMM_W = 16
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic [IMM_W-1:0] imm;
    logic [4:0]       shamt;
    logic             alu_src;
    logic             shamt_src;
    logic [2:0]       gin_in;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    a_out;
    logic [DW-1:0]    b_out;
    logic [2:0]       gin_out;

    modport master (
        output flush, in_valid, rs, rt, imm, shamt, alu_src, shamt_src, gin_in,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, a_out, b_out, gin_out
    );

    modport slave (
        input  flush, in_valid, rs, rt, imm, shamt, alu_src, shamt_src, gin_in,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, a_out, b_out, gin_out
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Register file with write-through bypass, ALU operand select and a one-entry output register.
// Latency: one cycle from accept to out_valid. A drain and a load can happen on the same edge.
// Backpressure: in_ready drops while the entry is held and out_ready is low, or while flush is high.
module alu_operand_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int IMM_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0] rf [NREG];
    logic          wr_hit;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic [DW-1:0] a_sel;
    logic [DW-1:0] b_sel;
    logic          accept;
    logic          vld_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [2:0]    gin_q;

    assign wr_hit = bus.wb_en && (bus.wb_addr != '0);

    // Write-back is independent of flush and of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_hit) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd_a = rf[bus.rs];
        if (bus.rs == '0) rd_a = '0;
        if (wr_hit && (bus.wb_addr == bus.rs)) rd_a = bus.wb_data;
        rd_b = rf[bus.rt];
        if (bus.rt == '0) rd_b = '0;
        if (wr_hit && (bus.wb_addr == bus.rt)) rd_b = bus.wb_data;
    end

    assign a_sel = bus.shamt_src ? {{(DW-5){1'b0}}, bus.shamt} : rd_a;
    assign b_sel = bus.alu_src ? {{(DW-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : rd_b;

    assign bus.in_ready = rst_n & ~bus.flush & (~vld_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Flush wins over both accept and drain; operand bits are left stale on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            gin_q <= 3'b000;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
            a_q   <= a_sel;
            b_q   <= b_sel;
            gin_q <= bus.gin_in;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.gin_out   = gin_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus a random run against a register-file/valid model.
module tb_alu_operand_stage;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int IMM_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.DW(DW), .AW(AW), .IMM_W(IMM_W)) bus ();

    alu_operand_stage #(.DW(DW), .AW(AW), .IMM_W(IMM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference state: architectural registers plus the single output slot.
    logic [DW-1:0] m_rf [32];
    logic          m_valid;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic [2:0]    m_gin;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] addr);
        if (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == addr) return bus.wb_data;
        if (addr == 0) return '0;
        return m_rf[addr];
    endfunction

    function automatic logic m_in_ready();
        return rst_n && !bus.flush && (!m_valid || bus.out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_gin   = 3'b000;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.imm       = '0;
        bus.shamt     = '0;
        bus.alu_src   = 1'b0;
        bus.shamt_src = 1'b0;
        bus.gin_in    = 3'b000;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge. Returns at the negedge.
    task automatic tick();
        logic          acc;
        logic [DW-1:0] na;
        logic [DW-1:0] nb;
        acc = bus.in_valid && m_in_ready();
        na  = bus.shamt_src ? DW'(bus.shamt) : m_read(bus.rs);
        nb  = bus.alu_src ? DW'($signed(bus.imm)) : m_read(bus.rt);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
            if (bus.flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_a     = na;
                m_b     = nb;
                m_gin   = bus.gin_in;
            end else if (bus.out_ready) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.a_out !== '0) begin failures++; $display("FAIL reset_a got=%h exp=0", bus.a_out); end
        checks++; if (bus.b_out !== '0) begin failures++; $display("FAIL reset_b got=%h exp=0", bus.b_out); end
        checks++; if (bus.gin_out !== 3'b000) begin failures++; $display("FAIL reset_gin got=%b exp=000", bus.gin_out); end
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rf_r0();
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        tick();
        bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
        tick();
        idle();
        bus.in_valid = 1'b1; bus.rs = 5'd5; bus.rt = 5'd0; bus.gin_in = 3'b101;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rf_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rf_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.a_out !== 32'hDEADBEEF) begin failures++; $display("FAIL rf_a got=%h exp=deadbeef", bus.a_out); end
        checks++; if (bus.b_out !== 32'h0) begin failures++; $display("FAIL rf_r0_b got=%h exp=0", bus.b_out); end
        checks++; if (bus.gin_out !== 3'b101) begin failures++; $display("FAIL rf_gin got=%b exp=101", bus.gin_out); end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h55;
        bus.in_valid = 1'b1; bus.rs = 5'd7; bus.rt = 5'd7;
        tick();
        idle();
        #1;
        checks++; if (bus.a_out !== 32'h55) begin failures++; $display("FAIL bypass_a got=%h exp=55", bus.a_out); end
        checks++; if (bus.b_out !== 32'h55) begin failures++; $display("FAIL bypass_b got=%h exp=55", bus.b_out); end
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        bus.in_valid = 1'b1; bus.rs = 5'd0; bus.rt = 5'd0;
        tick();
        idle();
        #1;
        checks++; if (bus.a_out !== 32'h0) begin failures++; $display("FAIL bypass_r0_a got=%h exp=0", bus.a_out); end
        checks++; if (bus.b_out !== 32'h0) begin failures++; $display("FAIL bypass_r0_b got=%h exp=0", bus.b_out); end
        tick();
    endtask

    task automatic test_opsel();
        idle();
        bus.in_valid = 1'b1; bus.rs = 5'd5; bus.rt = 5'd7;
        bus.imm = 16'hFFFC; bus.alu_src = 1'b1;
        bus.shamt = 5'd4; bus.shamt_src = 1'b1; bus.gin_in = 3'b011;
        tick();
        idle();
        #1;
        checks++; if (bus.a_out !== 32'h4) begin failures++; $display("FAIL opsel_shamt got=%h exp=4", bus.a_out); end
        checks++; if (bus.b_out !== 32'hFFFFFFFC) begin failures++; $display("FAIL opsel_sext_neg got=%h exp=fffffffc", bus.b_out); end
        checks++; if (bus.gin_out !== 3'b011) begin failures++; $display("FAIL opsel_gin got=%b exp=011", bus.gin_out); end
        bus.in_valid = 1'b1; bus.rs = 5'd5; bus.imm = 16'h7FF0; bus.alu_src = 1'b1;
        bus.shamt = 5'd31; bus.shamt_src = 1'b0;
        tick();
        idle();
        #1;
        checks++; if (bus.a_out !== 32'hDEADBEEF) begin failures++; $display("FAIL opsel_reg_a got=%h exp=deadbeef", bus.a_out); end
        checks++; if (bus.b_out !== 32'h00007FF0) begin failures++; $display("FAIL opsel_sext_pos got=%h exp=00007ff0", bus.b_out); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] prev_a;
        logic [2:0]    prev_g;
        idle();
        bus.in_valid = 1'b1; bus.rs = 5'd5; bus.rt = 5'd7; bus.gin_in = 3'b001;
        tick();
        bus.out_ready = 1'b0;
        bus.shamt_src = 1'b1; bus.shamt = 5'd9; bus.alu_src = 1'b1; bus.imm = 16'h0010; bus.gin_in = 3'b110;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.a_out !== 32'hDEADBEEF || bus.b_out !== 32'h55 || bus.gin_out !== 3'b001) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b a=%h b=%h g=%b exp v=1 a=deadbeef b=55 g=001", c, bus.out_valid, bus.a_out, bus.b_out, bus.gin_out);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        tick();
        prev_a = 32'd9;
        prev_g = 3'b110;
        for (int k = 0; k < 4; k++) begin
            bus.shamt = 5'(k + 20); bus.imm = 16'(k * 3 + 100); bus.gin_in = 3'(k);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.a_out !== prev_a || bus.gin_out !== prev_g) begin
                failures++;
                $display("FAIL b2b_op k=%0d got v=%b a=%h g=%b exp v=1 a=%h g=%b", k, bus.out_valid, bus.a_out, bus.gin_out, prev_a, prev_g);
            end
            tick();
            prev_a = DW'(k + 20);
            prev_g = 3'(k);
        end
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.a_out !== prev_a || bus.b_out !== 32'd109) begin
            failures++;
            $display("FAIL b2b_last got v=%b a=%h b=%h exp v=1 a=%h b=6d", bus.out_valid, bus.a_out, bus.b_out, prev_a);
        end
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] data;
        data = $urandom;
        idle();
        bus.in_valid = 1'b1; bus.rs = 5'd5;
        tick();
        bus.out_ready = 1'b0; bus.flush = 1'b1; bus.rs = 5'd7;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = data;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        bus.in_valid = 1'b1; bus.rs = 5'd9;
        tick();
        idle();
        #1;
        checks++; if (bus.a_out !== data) begin failures++; $display("FAIL flush_wb got=%h exp=%h", bus.a_out, data); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.rs        = AW'($urandom);
            bus.rt        = AW'($urandom);
            bus.imm       = IMM_W'($urandom);
            bus.shamt     = 5'($urandom);
            bus.alu_src   = 1'($urandom);
            bus.shamt_src = 1'($urandom);
            bus.gin_in    = 3'($urandom);
            bus.wb_en     = 1'($urandom);
            bus.wb_addr   = ($urandom_range(0, 2) == 0) ? bus.rs : AW'($urandom);
            bus.wb_data   = $urandom;
            #1;
            checks++; if (bus.in_ready !== m_in_ready()) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, m_in_ready()); end
            checks++; if (bus.out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.a_out !== m_a || bus.b_out !== m_b || bus.gin_out !== m_gin) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got a=%h b=%h g=%b exp a=%h b=%h g=%b", c, bus.a_out, bus.b_out, bus.gin_out, m_a, m_b, m_gin);
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midop();
        idle();
        for (int r = 1; r < 32; r++) begin
            bus.wb_en = 1'b1; bus.wb_addr = 5'(r); bus.wb_data = $urandom | 32'h1;
            tick();
        end
        idle();
        bus.in_valid = 1'b1; bus.rs = 5'd5; bus.rt = 5'd9;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.a_out !== '0 || bus.b_out !== '0) begin failures++; $display("FAIL midrst_ops got a=%h b=%h exp 0", bus.a_out, bus.b_out); end
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        for (int r = 1; r < 33; r++) begin
            bus.in_valid = (r < 32); bus.rs = 5'(r); bus.rt = 5'(r);
            #1;
            if (r > 1) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.a_out !== '0 || bus.b_out !== '0) begin
                    failures++;
                    $display("FAIL midrst_rf r=%0d got v=%b a=%h b=%h exp v=1 a=0 b=0", r - 1, bus.out_valid, bus.a_out, bus.b_out);
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rf_r0();
        test_bypass();
        test_opsel();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
